fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of fifo_with_delay among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter drives the FIFO's write_en/data_in and honours its full flag.
- Burst lock lets a granted producer keep the port for up to MAX_BURST consecutive beats, which keeps its data contiguous in the FIFO.

Parameters:
- NUM_REQ, 4, number of producers (>=2)
- DATA_WIDTH, 8, data width; must match the FIFO
- MAX_BURST, 2, maximum consecutive beats per grant (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-producer valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-producer accept, one-hot or zero
- fifo_full  input  1  full flag from the FIFO
- fifo_write_en  output  1  to the FIFO write_en
- fifo_data_in  output  DATA_WIDTH  to the FIFO data_in
- grant_id  output  $clog2(NUM_REQ)  index of the producer accepted this cycle; 0 when none
- burst_active  output  1  high while in ARB_BURST
- stats_clr  input  1  (FIFO_ARB_STATS_EN only) clear counters
- grant_cnt  output  NUM_REQ*16  (FIFO_ARB_STATS_EN only) per-producer beat counters

Behaviour:
- Transfer definition: a beat transfers when req_valid[i] && req_ready[i].
- Handshake timing: ready is combinational from registered state, req_valid and fifo_full. Zero-cycle latency to the FIFO write port.
- Producer rule: req_data/req_valid stay stable while valid && !ready.
- Invariants:
  - fifo_write_en == |req_ready.
  - fifo_data_in = data of the granted producer, else 0.
  - fifo_write_en is never high while fifo_full is high.
- Registered state:
  - state: ARB_IDLE/ARB_BURST
  - rr_ptr: highest-priority index
  - owner
  - beat count, width $clog2(MAX_BURST+1)
- Reset:
  - state=ARB_IDLE, rr_ptr=0, owner=0, beats=0.
  - While rst is high, all ready bits, fifo_write_en, fifo_data_in, grant_id and burst_active are forced 0. No transfer occurs in a reset cycle.
- ARB_IDLE:
  - If !fifo_full and any valid: grant g = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ (wraps NUM_REQ-1 -> 0). Transfer occurs.
  - If MAX_BURST==1: rr_ptr <= (g+1) mod NUM_REQ, stay in IDLE.
  - Else: owner <= g, beats <= 1, go to ARB_BURST.
  - If none valid, or fifo_full: no grant, state unchanged.
- ARB_BURST:
  - Owner valid && !fifo_full: transfer; beats++. If beats+1 == MAX_BURST, go to IDLE and set rr_ptr <= (owner+1) mod NUM_REQ.
  - Owner valid && fifo_full: stall. No ready, beats held, state held.
  - Owner not valid: release. No transfer this cycle (one bubble), go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ. Applies even if fifo_full.
- Other producers never receive ready while in BURST.
- Reset mid-burst: the burst is abandoned. The next cycle starts in IDLE with rr_ptr=0.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - stats_clr and grant_cnt ports exist.
  - Per-producer 16-bit counter increments on each transfer of that producer and saturates at 16'hFFFF.
  - stats_clr is synchronous; clear wins over a same-cycle increment.
  - Counters reset to 0 on rst.
- Undefined: no counters and no ports. Arbitration is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_BURST}
  - localparam STAT_W=16
  - helper function for the index width
- Sub-module fifo_rr_pick: combinational rotating priority encoder.
  - Inputs: valid vector, rr_ptr.
  - Outputs: hit, index.

Test Plan:
- Round-robin with bursts (NUM_REQ=4, MAX_BURST=2, DATA_WIDTH=8): after reset, all valid with data 8'h10/20/30/40, full=0 -> FIFO writes 10,10,20,20,30,30,40,40,10,10 on consecutive cycles; burst_active high on second beats.
- Single producer: only req 2 valid, held 6 cycles -> fifo_write_en high every cycle, grant_id=2 throughout, six writes of its data.
- Mid-burst drop: req1 gives one beat then drops valid while req3 is valid -> one bubble cycle with write_en=0, then req3 granted; rr_ptr=2 at the re-arbitration cycle.
- Full stall: fifo_full high for 3 cycles after the first beat of req0's burst -> ready/write_en low for 3 cycles, then exactly one more req0 beat, then req1 granted.
- Reset mid-burst: rst pulsed 1 cycle during req3's burst with all valid -> no write in the reset cycle, next grant to req0.
- Stats (FIFO_ARB_STATS_EN defined): 5 transfers by req0 -> grant_cnt[15:0]=5; stats_clr pulse in a transfer cycle -> 0; preload check that 16'hFFFF stays at 16'hFFFF on a further transfer.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Holds the arbiter state encoding, counter width and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating priority encoder: returns the first set bit of valid at or after
// rr_ptr, wrapping from NUM_REQ-1 back to 0.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               hit,
  output logic [IDX_W-1:0]   index
);

  int cand;

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (valid[IDX_W'(cand)]) begin
        hit   = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-producer beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 2,
  localparam int IDX_W  = idx_width(NUM_REQ),
  localparam int BEAT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IDX_W-1:0]              grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [NUM_REQ*STAT_W-1:0]     grant_cnt,
`endif
  output logic                          burst_active
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic [IDX_W-1:0]   grant_idx;
  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_q),
    .hit    (pick_hit),
    .index  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
    end
  end

  // A released or completed burst hands priority to the producer after the owner.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    beats_d   = beats_q;
    req_ready = '0;
    grant_idx = '0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_hit && !fifo_full) begin
            req_ready[pick_idx] = 1'b1;
            grant_idx           = pick_idx;
            if (MAX_BURST == 1) begin
              rr_d = next_idx(pick_idx);
            end else begin
              owner_d = pick_idx;
              beats_d = BEAT_W'(1);
              state_d = ARB_BURST;
            end
          end
        end
        ARB_BURST: begin
          if (req_valid[owner_q]) begin
            if (!fifo_full) begin
              req_ready[owner_q] = 1'b1;
              grant_idx          = owner_q;
              if (beats_q + 1'b1 == BEAT_W'(MAX_BURST)) begin
                state_d = ARB_IDLE;
                rr_d    = next_idx(owner_q);
                beats_d = '0;
              end else begin
                beats_d = beats_q + 1'b1;
              end
            end
          end else begin
            state_d = ARB_IDLE;
            rr_d    = next_idx(owner_q);
            beats_d = '0;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign fifo_write_en = |req_ready;
  assign fifo_data_in  = fifo_write_en ? req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]
                                       : '0;
  assign grant_id      = grant_idx;
  assign burst_active  = !rst && (state_q == ARB_BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];

  // Clear takes precedence over a same-cycle beat; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || stats_clr) begin
        cnt_q[i] <= '0;
      end else if (req_ready[i] && req_valid[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a grant-sequence reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_write_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_id;
  logic          burst_active;
  logic          stats_clr;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: priority start, burst lock holder and beats used so far.
  int m_prio, m_lock, m_id, m_beats;
  int m_cnt [N];
  int e_g;
  logic [N-1:0]  e_ready;
  logic          e_we;
  logic [DW-1:0] e_data;
  logic [1:0]    e_gid;
  logic          e_burst;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant_id      (grant_id),
`ifdef FIFO_ARB_STATS_EN
    .stats_clr     (stats_clr),
    .grant_cnt     (grant_cnt),
`endif
    .burst_active  (burst_active)
  );

  task automatic model_eval();
    e_g = -1;
    if (!rst) begin
      if (m_lock != 0) begin
        if (req_valid[m_id] && !fifo_full) e_g = m_id;
      end else if (!fifo_full) begin
        for (int j = 0; j < N; j++) begin
          int k;
          k = (m_prio + j) % N;
          if (e_g < 0 && req_valid[k]) e_g = k;
        end
      end
    end
    e_ready = (e_g >= 0) ? (N'(1) << e_g) : '0;
    e_we    = (e_g >= 0);
    e_data  = (e_g >= 0) ? req_data[e_g*DW +: DW] : '0;
    e_gid   = (e_g >= 0) ? 2'(e_g) : 2'd0;
    e_burst = !rst && (m_lock != 0);
  endtask

  task automatic model_commit();
    if (rst) begin
      m_prio = 0; m_lock = 0; m_id = 0; m_beats = 0;
    end else if (m_lock != 0) begin
      if (!req_valid[m_id]) begin
        m_lock = 0;
        m_prio = (m_id + 1) % N;
      end else if (e_g >= 0) begin
        m_beats++;
        if (m_beats == MB) begin
          m_lock = 0;
          m_prio = (m_id + 1) % N;
        end
      end
    end else if (e_g >= 0) begin
      if (MB == 1) m_prio = (e_g + 1) % N;
      else begin
        m_lock = 1; m_id = e_g; m_beats = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rst || stats_clr) m_cnt[i] = 0;
      else if (e_g == i && m_cnt[i] < 65535) m_cnt[i]++;
    end
  endtask

  // Called at posedge+1: apply inputs, settle to mid-cycle, compute expectations.
  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic f, input logic r, input logic c);
    req_valid = v; req_data = d; fifo_full = f; rst = r; stats_clr = c;
    #4;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  localparam logic [N*DW-1:0] DATA4 = {8'h40, 8'h30, 8'h20, 8'h10};

  task automatic test_reset();
    drive('1, DATA4, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active} !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h want 0000",
               {req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active});
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_w [10];
    exp_w = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h30, 8'h30, 8'h40, 8'h40, 8'h10, 8'h10};
    drive('1, DATA4, 1'b0, 1'b1, 1'b0); tick();
    for (int k = 0; k < 10; k++) begin
      drive('1, DATA4, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({fifo_write_en, fifo_data_in, burst_active} !== {1'b1, exp_w[k], 1'(k % 2)}) begin
        n_fail++;
        $display("[TB] FAIL rr_beat%0d: got we=%b data=%h burst=%b want we=1 data=%h burst=%0d",
                 k, fifo_write_en, fifo_data_in, burst_active, exp_w[k], k % 2);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [N*DW-1:0] d;
    d = {8'h00, 8'hA5, 8'h00, 8'h00};
    drive('0, d, 1'b0, 1'b1, 1'b0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0100, d, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({fifo_write_en, grant_id, fifo_data_in, req_ready} !== {1'b1, 2'd2, 8'hA5, 4'b0100}) begin
        n_fail++;
        $display("[TB] FAIL single_beat%0d: got we=%b gid=%0d data=%h ready=%b want we=1 gid=2 data=a5 ready=0100",
                 k, fifo_write_en, grant_id, fifo_data_in, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_mid_burst_drop();
    drive('0, DATA4, 1'b0, 1'b1, 1'b0); tick();
    drive(4'b1010, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id, fifo_data_in} !== {1'b1, 2'd1, 8'h20}) begin
      n_fail++;
      $display("[TB] FAIL drop_first: got we=%b gid=%0d data=%h want we=1 gid=1 data=20",
               fifo_write_en, grant_id, fifo_data_in);
    end
    tick();
    drive(4'b1000, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, req_ready} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_bubble: got we=%b ready=%b want we=0 ready=0000",
               fifo_write_en, req_ready);
    end
    tick();
    // req0 also valid: picking req3 shows the priority start moved to 2.
    drive(4'b1001, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id, fifo_data_in} !== {1'b1, 2'd3, 8'h40}) begin
      n_fail++;
      $display("[TB] FAIL drop_regrant: got we=%b gid=%0d data=%h want we=1 gid=3 data=40",
               fifo_write_en, grant_id, fifo_data_in);
    end
    tick();
  endtask

  task automatic test_full_stall();
    drive('0, DATA4, 1'b0, 1'b1, 1'b0); tick();
    drive('1, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL stall_first: got we=%b gid=%0d want we=1 gid=0", fifo_write_en, grant_id);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive('1, DATA4, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({req_ready, fifo_write_en, burst_active} !== 6'b000001) begin
        n_fail++;
        $display("[TB] FAIL stall_hold%0d: got ready=%b we=%b burst=%b want ready=0000 we=0 burst=1",
                 k, req_ready, fifo_write_en, burst_active);
      end
      tick();
    end
    drive('1, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id, fifo_data_in} !== {1'b1, 2'd0, 8'h10}) begin
      n_fail++;
      $display("[TB] FAIL stall_resume: got we=%b gid=%0d data=%h want we=1 gid=0 data=10",
               fifo_write_en, grant_id, fifo_data_in);
    end
    tick();
    drive('1, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL stall_next: got we=%b gid=%0d want we=1 gid=1", fifo_write_en, grant_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int seq [7];
    seq = '{0, 0, 1, 1, 2, 2, 3};
    drive('0, DATA4, 1'b0, 1'b1, 1'b0); tick();
    for (int k = 0; k < 7; k++) begin
      drive('1, DATA4, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({fifo_write_en, grant_id} !== {1'b1, 2'(seq[k])}) begin
        n_fail++;
        $display("[TB] FAIL rstburst_pre%0d: got we=%b gid=%0d want we=1 gid=%0d",
                 k, fifo_write_en, grant_id, seq[k]);
      end
      tick();
    end
    drive('1, DATA4, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active} !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL rstburst_cycle: got %h want 0000",
               {req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active});
    end
    tick();
    drive('1, DATA4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({fifo_write_en, grant_id, burst_active} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rstburst_after: got we=%b gid=%0d burst=%b want we=1 gid=0 burst=0",
               fifo_write_en, grant_id, burst_active);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    held;
    v = '0; d = '0; held = '0;
    drive('0, '0, 1'b0, 1'b1, 1'b1); tick();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          v[i] = (($urandom % 5) < 3);
          d[i*DW +: DW] = DW'($urandom);
        end
      end
      drive(v, d, ($urandom % 4) == 0, ($urandom % 60) == 0, ($urandom % 40) == 0);
      n_cmp++;
      if ({req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active} !==
          {e_ready, e_we, e_data, e_gid, e_burst}) begin
        n_fail++;
        $display("[TB] FAIL random_cyc%0d: got ready=%b we=%b data=%h gid=%0d burst=%b want ready=%b we=%b data=%h gid=%0d burst=%b",
                 c, req_ready, fifo_write_en, fifo_data_in, grant_id, burst_active,
                 e_ready, e_we, e_data, e_gid, e_burst);
      end
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
          n_fail++;
          $display("[TB] FAIL random_cnt%0d_cyc%0d: got %0d want %0d",
                   i, c, grant_cnt[i*16 +: 16], m_cnt[i]);
        end
      end
`endif
      held = v & ~e_ready;
      tick();
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    logic [N*DW-1:0] d;
    d = {8'h00, 8'h00, 8'h00, 8'h5A};
    drive('0, d, 1'b0, 1'b1, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, d, 1'b0, 1'b0, 1'b0); tick();
    end
    n_cmp++;
    if (grant_cnt[15:0] !== 16'd5) begin
      n_fail++;
      $display("[TB] FAIL stats_five: got %0d want 5", grant_cnt[15:0]);
    end
    drive(4'b0001, d, 1'b0, 1'b0, 1'b1); tick();
    n_cmp++;
    if (grant_cnt[15:0] !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL stats_clear: got %0d want 0", grant_cnt[15:0]);
    end
    for (int k = 0; k < 65535; k++) begin
      drive(4'b0001, d, 1'b0, 1'b0, 1'b0); tick();
    end
    n_cmp++;
    if (grant_cnt[15:0] !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL stats_top: got %h want ffff", grant_cnt[15:0]);
    end
    drive(4'b0001, d, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (grant_cnt[15:0] !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL stats_saturate: got %h want ffff", grant_cnt[15:0]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; stats_clr = 1'b0;
    m_prio = 0; m_lock = 0; m_id = 0; m_beats = 0; e_g = -1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_single();
    test_mid_burst_drop();
    test_full_stall();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
